// File: rtl/fluxo_dados_drone_param.sv
// Drone-game datapath: column/lane position, writable obstacle map, move timer,
// hit detection with lives counter and sticky game-over.
module fluxo_dados_drone_param #(
    parameter int LANES        = 4,
    parameter int MAP_DEPTH    = 16,
    parameter int TEMPO_JOGADA = 1000,
    parameter int VIDAS        = 3,
    parameter int START_LANE   = LANES / 2,
    localparam int VW = (LANES > 2) ? $clog2(LANES) : 1,
    localparam int HW = $clog2(MAP_DEPTH),
    localparam int TW = $clog2(TEMPO_JOGADA),
    localparam int LW = $clog2(VIDAS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zeraPosicoes,
    input  logic             desloca,
    input  logic [1:0]       controle,
    input  logic             contaT,
    input  logic             zeraT,
    input  logic             we_mapa,
    input  logic [HW-1:0]    addr_mapa,
    input  logic [LANES-1:0] dado_mapa,
    output logic             colisao,
    output logic             batida,
    output logic             fim_espera,
    output logic             fim_mapa,
    output logic             game_over,
    output logic [LW-1:0]    vidas,
    output logic [HW-1:0]    db_posicao_horizontal,
    output logic [LANES-1:0] db_posicao_vertical,
    output logic [LANES-1:0] db_obstaculos
);

    logic [LANES-1:0] mapa [MAP_DEPTH];
    logic [HW-1:0]    h;
    logic [VW-1:0]    v;
    logic [TW-1:0]    t;
    logic [HW-1:0]    h_prox;
    logic [VW-1:0]    v_prox;
    logic [LANES-1:0] obst;
    logic             acerto;

    // Map RAM holds level data across resets, so it has no reset branch.
    always_ff @(posedge clock) begin
        if (we_mapa)
            mapa[addr_mapa] <= dado_mapa;
    end

    // MAP_DEPTH is a power of two, so the natural overflow gives the wrap.
    assign h_prox = h + HW'(1);
    assign obst   = mapa[h_prox];

    always_comb begin
        v_prox = v;
        if (controle == 2'b01) begin
            if (v != VW'(LANES - 1))
                v_prox = v + VW'(1);
        end else if (controle == 2'b10) begin
            if (v != '0)
                v_prox = v - VW'(1);
        end
    end

    // Hits are judged on the destination lane, not on the current-lane preview.
    assign acerto = obst[v_prox];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h         <= '0;
            v         <= VW'(START_LANE);
            vidas     <= LW'(VIDAS);
            game_over <= 1'b0;
            batida    <= 1'b0;
        end else if (zeraPosicoes) begin
            h         <= '0;
            v         <= VW'(START_LANE);
            vidas     <= LW'(VIDAS);
            game_over <= 1'b0;
            batida    <= 1'b0;
        end else begin
            batida <= 1'b0;
            if (desloca && !game_over) begin
                h <= h_prox;
                v <= v_prox;
                if (acerto) begin
                    batida <= 1'b1;
                    if (vidas != '0)
                        vidas <= vidas - LW'(1);
                    if (vidas == LW'(1))
                        game_over <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            t <= '0;
        else if (zeraT)
            t <= '0;
        else if (contaT)
            t <= (t == TW'(TEMPO_JOGADA - 1)) ? '0 : t + TW'(1);
    end

    assign fim_espera            = (t == TW'(TEMPO_JOGADA - 1));
    assign fim_mapa              = (h == HW'(MAP_DEPTH - 1));
    assign colisao               = obst[v];
    assign db_obstaculos         = obst;
    assign db_posicao_horizontal = h;
    assign db_posicao_vertical   = LANES'(1) << v;

endmodule

// File: tb/tb_fluxo_dados_drone_param.sv
// Directed bench for fluxo_dados_drone_param with a 5-cycle move timer.
module tb_fluxo_dados_drone_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       zeraPosicoes;
    logic       desloca;
    logic [1:0] controle;
    logic       contaT;
    logic       zeraT;
    logic       we_mapa;
    logic [3:0] addr_mapa;
    logic [3:0] dado_mapa;
    logic       colisao;
    logic       batida;
    logic       fim_espera;
    logic       fim_mapa;
    logic       game_over;
    logic [1:0] vidas;
    logic [3:0] db_posicao_horizontal;
    logic [3:0] db_posicao_vertical;
    logic [3:0] db_obstaculos;

    int checks = 0;
    int errors = 0;

    fluxo_dados_drone_param #(.TEMPO_JOGADA(5)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .zeraPosicoes          (zeraPosicoes),
        .desloca               (desloca),
        .controle              (controle),
        .contaT                (contaT),
        .zeraT                 (zeraT),
        .we_mapa               (we_mapa),
        .addr_mapa             (addr_mapa),
        .dado_mapa             (dado_mapa),
        .colisao               (colisao),
        .batida                (batida),
        .fim_espera            (fim_espera),
        .fim_mapa              (fim_mapa),
        .game_over             (game_over),
        .vidas                 (vidas),
        .db_posicao_horizontal (db_posicao_horizontal),
        .db_posicao_vertical   (db_posicao_vertical),
        .db_obstaculos         (db_obstaculos)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input logic [3:0] h, input logic [3:0] v1h);
        chk({tag, "_h"}, 32'(db_posicao_horizontal), 32'(h));
        chk({tag, "_v"}, 32'(db_posicao_vertical), 32'(v1h));
    endtask

    initial begin
        reset = 1'b1; zeraPosicoes = 1'b0; desloca = 1'b0; controle = 2'b00;
        contaT = 1'b0; zeraT = 1'b0; we_mapa = 1'b0; addr_mapa = '0; dado_mapa = '0;
        step();
        step();
        reset = 1'b0;

        // Clear the map while the timer runs, then move twice upward.
        contaT = 1'b1;
        for (int a = 0; a < 16; a++) begin
            we_mapa = 1'b1; addr_mapa = 4'(a); dado_mapa = 4'b0000;
            step();
        end
        we_mapa = 1'b0;
        desloca = 1'b1; controle = 2'b01;
        step();
        step();
        desloca = 1'b0; controle = 2'b00;
        chk_pos("pre_reset", 4'd2, 4'b1000);

        // Asynchronous reset mid-count.
        contaT = 1'b0;
        reset = 1'b1;
        #1;
        chk_pos("reset", 4'd0, 4'b0100);
        chk("reset_vidas", 32'(vidas), 32'd3);
        chk("reset_go", 32'(game_over), 32'd0);
        chk("reset_batida", 32'(batida), 32'd0);
        chk("reset_fim_espera", 32'(fim_espera), 32'd0);
        chk("reset_fim_mapa", 32'(fim_mapa), 32'd0);
        step();
        reset = 1'b0;
        chk("map_kept_obst", 32'(db_obstaculos), 32'd0);
        chk("map_kept_colisao", 32'(colisao), 32'd0);

        // Upward saturation.
        desloca = 1'b1; controle = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_pos("sat_up", 4'(i), 4'b1000);
        end
        // Downward saturation.
        controle = 2'b10;
        step(); chk_pos("sat_dn1", 4'd4, 4'b0100);
        step(); chk_pos("sat_dn2", 4'd5, 4'b0010);
        step(); chk_pos("sat_dn3", 4'd6, 4'b0001);
        step(); chk_pos("sat_dn4", 4'd7, 4'b0001);
        desloca = 1'b0; controle = 2'b00;

        // Horizontal wrap over 17 moves.
        zeraPosicoes = 1'b1;
        step();
        zeraPosicoes = 1'b0;
        chk_pos("zera1", 4'd0, 4'b0100);
        desloca = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            chk("wrap_h", 32'(db_posicao_horizontal), 32'(i % 16));
            chk("wrap_fim_mapa", 32'(fim_mapa), (i == 15) ? 32'd1 : 32'd0);
        end
        desloca = 1'b0;

        // Single collision on the destination lane.
        zeraPosicoes = 1'b1;
        we_mapa = 1'b1; addr_mapa = 4'd1; dado_mapa = 4'b1000;
        step();
        zeraPosicoes = 1'b0; we_mapa = 1'b0;
        chk("col_obst", 32'(db_obstaculos), 32'b1000);
        chk("col_preview", 32'(colisao), 32'd0);
        desloca = 1'b1; controle = 2'b01;
        step();
        desloca = 1'b0; controle = 2'b00;
        chk_pos("col_move", 4'd1, 4'b1000);
        chk("col_batida", 32'(batida), 32'd1);
        chk("col_vidas", 32'(vidas), 32'd2);
        step();
        chk("col_batida_clr", 32'(batida), 32'd0);
        chk("col_vidas_hold", 32'(vidas), 32'd2);

        // Game over after three consecutive hits.
        we_mapa = 1'b1; dado_mapa = 4'b0100;
        addr_mapa = 4'd1; step();
        addr_mapa = 4'd2; step();
        addr_mapa = 4'd3; step();
        we_mapa = 1'b0;
        zeraPosicoes = 1'b1;
        step();
        zeraPosicoes = 1'b0;
        chk("go_preview", 32'(colisao), 32'd1);
        desloca = 1'b1;
        step(); chk("go_vidas1", 32'(vidas), 32'd2); chk("go_bat1", 32'(batida), 32'd1);
        chk("go_flag1", 32'(game_over), 32'd0);
        step(); chk("go_vidas2", 32'(vidas), 32'd1); chk("go_bat2", 32'(batida), 32'd1);
        chk("go_flag2", 32'(game_over), 32'd0);
        step(); chk("go_vidas3", 32'(vidas), 32'd0); chk("go_bat3", 32'(batida), 32'd1);
        chk("go_flag3", 32'(game_over), 32'd1);
        chk_pos("go_pos", 4'd3, 4'b0100);
        controle = 2'b01;
        step();
        chk_pos("go_frozen", 4'd3, 4'b0100);
        chk("go_frozen_vidas", 32'(vidas), 32'd0);
        chk("go_frozen_bat", 32'(batida), 32'd0);
        chk("go_sticky", 32'(game_over), 32'd1);
        desloca = 1'b0; controle = 2'b00;
        zeraPosicoes = 1'b1;
        step();
        zeraPosicoes = 1'b0;
        chk_pos("go_restart", 4'd0, 4'b0100);
        chk("go_restart_vidas", 32'(vidas), 32'd3);
        chk("go_restart_flag", 32'(game_over), 32'd0);

        // Move timer: wrap and zeraT priority.
        contaT = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("tmr_wrap", 32'(fim_espera), (i == 4) ? 32'd1 : 32'd0);
        end
        step(); step();
        zeraT = 1'b1;
        step();
        zeraT = 1'b0;
        chk("tmr_zera", 32'(fim_espera), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("tmr_after_zera", 32'(fim_espera), (i == 4) ? 32'd1 : 32'd0);
        end
        contaT = 1'b0;

        // zeraPosicoes beats desloca.
        desloca = 1'b1;
        step();
        chk("pri_pre_h", 32'(db_posicao_horizontal), 32'd1);
        zeraPosicoes = 1'b1;
        step();
        zeraPosicoes = 1'b0; desloca = 1'b0;
        chk_pos("pri_zera", 4'd0, 4'b0100);
        chk("pri_batida", 32'(batida), 32'd0);
        chk("pri_vidas", 32'(vidas), 32'd3);

        // Write into the judged column during the move: old word decides.
        we_mapa = 1'b1; addr_mapa = 4'd1; dado_mapa = 4'b0000; desloca = 1'b1;
        step();
        we_mapa = 1'b0; desloca = 1'b0;
        chk("wr_old_batida", 32'(batida), 32'd1);
        chk("wr_old_vidas", 32'(vidas), 32'd2);
        chk("wr_next_obst", 32'(db_obstaculos), 32'b0100);

        // Reset aborts a pending hit and preserves the map.
        reset = 1'b1;
        #1;
        chk("rst_abort_batida", 32'(batida), 32'd0);
        chk("rst_vidas", 32'(vidas), 32'd3);
        step();
        reset = 1'b0;
        chk("rst_map_col1", 32'(db_obstaculos), 32'b0000);
        desloca = 1'b1;
        step();
        desloca = 1'b0;
        chk("rst_map_col2", 32'(db_obstaculos), 32'b0100);
        chk("rst_map_colisao", 32'(colisao), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fluxo_dados_drone_param.md
# fluxo_dados_drone_param

Parametrised drone-game datapath that sits under the game control unit. It tracks the drone's horizontal column and vertical lane on an N-lane, D-column map held in a writable map RAM, and times each move. It flags obstacle collisions, counts remaining lives and raises a sticky game-over. It generalises the fixed 4-lane / 16-column datapath: lane count, map depth and move period are parameters, maps are loadable at run time, vertical motion saturates, and a lives counter is added.

## Interface
- LANES, 4, number of vertical lanes (≥2); VW = max(1, clog2(LANES))
- MAP_DEPTH, 16, map columns (power of 2, ≥2); HW = clog2(MAP_DEPTH)
- TEMPO_JOGADA, 1000, move-timer period in cycles (≥2); TW = clog2(TEMPO_JOGADA)
- VIDAS, 3, lives at game start (1..15); LW = clog2(VIDAS+1)
- START_LANE, LANES/2, lane loaded on position clear (< LANES)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- zeraPosicoes  in  1  synchronous game restart
- desloca  in  1  one-cycle move strobe
- controle  in  2  [0]=up, [1]=down; 00/11 = hold lane
- contaT  in  1  move-timer enable
- zeraT  in  1  synchronous move-timer clear
- we_mapa  in  1  map write enable
- addr_mapa  in  HW  map write address
- dado_mapa  in  LANES  column obstacle bits, bit i = lane i
- colisao  out  1  comb. preview: obstacle in next column, current lane
- batida  out  1  registered one-cycle hit pulse
- fim_espera  out  1  timer at TEMPO_JOGADA-1
- fim_mapa  out  1  column at MAP_DEPTH-1
- game_over  out  1  sticky, lives exhausted
- vidas  out  LW  lives remaining
- db_posicao_horizontal  out  HW  column H
- db_posicao_vertical  out  LANES  one-hot of lane V
- db_obstaculos  out  LANES  map word at column (H+1) mod MAP_DEPTH

## Operation
- Map RAM: MAP_DEPTH × LANES. Synchronous write, combinational read at (H+1) mod MAP_DEPTH. Contents are not affected by reset or zeraPosicoes.
- Write and read at the same address in one cycle: the read returns the old word until the edge.
- colisao = db_obstaculos[V], combinational.
- Move (desloca=1, game_over=0, zeraPosicoes=0):
  - H ← (H+1) mod MAP_DEPTH; wraps at MAP_DEPTH-1 to 0.
  - V' = V+1 if controle=01 (saturate at LANES-1); V-1 if 10 (saturate at 0); else V.
  - V ← V'.
- Hit: on a move, if obstacle word(H+1)[V'] = 1 then batida=1 in the next cycle and vidas decrements. Hits are judged on the destination lane, not the colisao preview.
- Lives: when vidas goes 1→0, game_over sets on the same edge. vidas never wraps below 0.
- game_over=1: desloca is ignored (H, V, vidas hold; batida=0). Only zeraPosicoes or reset clears it.
- zeraPosicoes (priority over desloca): H←0, V←START_LANE, vidas←VIDAS, game_over←0, batida←0. The move timer is untouched.
- Move timer T: zeraT (priority) → 0; else contaT → T+1, wrapping from TEMPO_JOGADA-1 to 0.
- fim_espera = (T == TEMPO_JOGADA-1), combinational.
- fim_mapa = (H == MAP_DEPTH-1), combinational.

## Timing
- reset asserted (async):
  - H=0, V=START_LANE, T=0, vidas=VIDAS, game_over=0, batida=0.
  - Hence fim_mapa=0, fim_espera=0, db_posicao_vertical=1<<START_LANE.
  - colisao and db_obstaculos follow map contents.
- All state updates are on the rising edge; move latency is 1 cycle. batida is valid exactly 1 cycle after the move edge.
- Map write at edge k is visible on db_obstaculos/colisao after edge k; no read latency.
- Simultaneous events:
  - zeraPosicoes beats desloca; zeraT beats contaT.
  - A write to the column being judged in the same cycle as desloca is not seen; the old word decides.
- Reset mid-game aborts any pending batida; the map is preserved.
- Back-to-back desloca every cycle is legal; each cycle is judged independently.

## Test plan
- Reset, defaults: assert reset mid-count → H=0, V=2, vidas=3, game_over=0, T=0, db_posicao_vertical=0100.
- Saturation/wrap: from V=2, apply 3 moves with controle=01 → V=3,3,3. Apply 17 moves → H wraps 15→0 and fim_mapa is high only at H=15.
- Collision: write addr 1 = 1000, V=2, apply desloca with controle=01 → H=1, V=3, batida=1 next cycle, vidas=2. colisao was 0 before the move.
- Game over: three hitting moves → vidas 3→2→1→0, game_over=1. A further desloca leaves H and V unchanged. zeraPosicoes → vidas=3, game_over=0, H=0, V=2.
- Timer: TEMPO_JOGADA=5, contaT=1 → fim_espera high on T=4, T returns to 0 next cycle. zeraT together with contaT → T=0.
- Priority: zeraPosicoes+desloca in the same cycle → H=0, no batida. Write addr 1 in the same cycle as a move into column 1 → old word used for the hit decision.
